// File: rtl/accel_array_ctrl_pkg.sv
// Shared types and constants for the memristive array sequencer.
// The strobe decode lives here so the FSM can register it alongside the state it moves into.
package accel_pkg;

    localparam int unsigned AddrW = 5;
    localparam int unsigned DataW = 4;

    typedef enum logic [1:0] {
        INFER = 2'b00,
        RDREG = 2'b01,
        RDMEM = 2'b10,
        PROG  = 2'b11
    } accel_op_e;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        RESP
    } accel_state_e;

    typedef struct packed {
        logic cbl;
        logic cblen;
        logic csl;
        logic cwl;
    } strobe_t;

    // Strobe levels that apply while the FSM sits in state st.
    function automatic strobe_t strobes_for(input accel_op_e op, input logic data,
                                            input accel_state_e st);
        strobe_t s;
        logic    phase;
        logic    pulse;
        s     = '0;
        phase = (st == SETUP) || (st == PULSE) || (st == HOLD);
        pulse = (st == PULSE);
        case (op)
            PROG: begin
                s.cblen = phase;
                s.cbl   = phase & data;
                s.cwl   = pulse;
            end
            RDMEM:   s.csl = pulse;
            INFER: begin
                s.cbl = phase;
                s.csl = pulse;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/accel_array_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous chip data bus.
module accel_sync2 #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/accel_array_ctrl.sv
// Command sequencer for the off-chip memristive accelerator: setup/pulse/hold strobe
// phases per command, then a registered response carrying the synchronized bit_out.
module accel_array_ctrl
    import accel_pkg::*;
#(
    parameter int unsigned SetupCycles = 2,
    parameter int unsigned HoldCycles  = 3,
    parameter int unsigned PulseW      = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [AddrW-1:0]  cmd_col_i,
    input  logic [AddrW-1:0]  cmd_row_i,
    input  logic              cmd_data_i,
    input  logic [PulseW-1:0] pulse_len_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DataW-1:0]  rsp_data_o,
    output logic              busy_o,
    input  logic [DataW-1:0]  bit_out_i,
    output logic [1:0]        instructions_o,
    output logic [AddrW-1:0]  addr_col_o,
    output logic [AddrW-1:0]  addr_row_o,
    output logic              cbl_o,
    output logic              cblen_o,
    output logic              csl_o,
    output logic              cwl_o
);

    localparam int unsigned PhaseMax = (SetupCycles > HoldCycles) ? SetupCycles : HoldCycles;
    localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
    localparam int unsigned CntW     = (PulseW > PhaseW) ? PulseW : PhaseW;

    accel_state_e      state_q;
    logic [CntW-1:0]   cnt_q;
    accel_op_e         op_q;
    logic              data_q;
    logic [PulseW-1:0] pulse_q;
    logic [AddrW-1:0]  col_q;
    logic [AddrW-1:0]  row_q;
    strobe_t           strb_q;
    logic              cmd_ready_q;
    logic              busy_q;
    logic              rsp_valid_q;
    logic [DataW-1:0]  rsp_data_q;
    logic [DataW-1:0]  bit_sync;

    accel_sync2 #(
        .Width(DataW)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (bit_out_i),
        .q_o   (bit_sync)
    );

    function automatic logic [CntW-1:0] eff_len(input logic [PulseW-1:0] len);
        return (len == '0) ? CntW'(1) : CntW'(len);
    endfunction

    // Outputs are loaded with the values of the state being entered, so every pin is a flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= INFER;
            data_q      <= 1'b0;
            pulse_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            strb_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op_q        <= accel_op_e'(cmd_op_i);
                        data_q      <= cmd_data_i;
                        pulse_q     <= pulse_len_i;
                        col_q       <= cmd_col_i;
                        row_q       <= cmd_row_i;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (SetupCycles == 0) begin
                            state_q <= PULSE;
                            cnt_q   <= eff_len(pulse_len_i);
                            strb_q  <= strobes_for(accel_op_e'(cmd_op_i), cmd_data_i, PULSE);
                        end else begin
                            state_q <= SETUP;
                            cnt_q   <= CntW'(SetupCycles);
                            strb_q  <= strobes_for(accel_op_e'(cmd_op_i), cmd_data_i, SETUP);
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q == CntW'(1)) begin
                        state_q <= PULSE;
                        cnt_q   <= eff_len(pulse_q);
                        strb_q  <= strobes_for(op_q, data_q, PULSE);
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                PULSE: begin
                    if (cnt_q == CntW'(1)) begin
                        state_q <= HOLD;
                        cnt_q   <= CntW'(HoldCycles);
                        strb_q  <= strobes_for(op_q, data_q, HOLD);
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == CntW'(1)) begin
                        state_q     <= RESP;
                        cnt_q       <= '0;
                        strb_q      <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= (op_q == PROG) ? '0 : bit_sync;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        op_q        <= INFER;
                        col_q       <= '0;
                        row_q       <= '0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    strb_q      <= '0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign busy_o         = busy_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign instructions_o = op_q;
    assign addr_col_o     = col_q;
    assign addr_row_o     = row_q;
    assign cbl_o          = strb_q.cbl;
    assign cblen_o        = strb_q.cblen;
    assign csl_o          = strb_q.csl;
    assign cwl_o          = strb_q.cwl;

endmodule

// File: tb/tb_accel_array_ctrl.sv
// Randomized scoreboard bench for accel_array_ctrl: the driver pushes expected per-command
// behaviour from a phase-length model, and a negedge monitor compares and retires it.
module tb_accel_array_ctrl;
    import accel_pkg::*;

    localparam int unsigned S  = 2;
    localparam int unsigned H  = 3;
    localparam int unsigned PW = 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i = '0;
    logic [4:0]    cmd_col_i = '0;
    logic [4:0]    cmd_row_i = '0;
    logic          cmd_data_i = 1'b0;
    logic [PW-1:0] pulse_len_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [3:0]    rsp_data_o;
    logic          busy_o;
    logic [3:0]    bit_out_i = '0;
    logic [1:0]    instructions_o;
    logic [4:0]    addr_col_o;
    logic [4:0]    addr_row_o;
    logic          cbl_o, cblen_o, csl_o, cwl_o;

    accel_array_ctrl #(
        .SetupCycles(S),
        .HoldCycles (H),
        .PulseW     (PW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_op_i      (cmd_op_i),
        .cmd_col_i     (cmd_col_i),
        .cmd_row_i     (cmd_row_i),
        .cmd_data_i    (cmd_data_i),
        .pulse_len_i   (pulse_len_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .busy_o        (busy_o),
        .bit_out_i     (bit_out_i),
        .instructions_o(instructions_o),
        .addr_col_o    (addr_col_o),
        .addr_row_o    (addr_row_o),
        .cbl_o         (cbl_o),
        .cblen_o       (cblen_o),
        .csl_o         (csl_o),
        .cwl_o         (cwl_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  col;
        logic [4:0]  row;
        logic [3:0]  rdata;
        int unsigned acc;
        int unsigned lat;
        int unsigned n_cbl;
        int unsigned n_cblen;
        int unsigned n_csl;
        int unsigned n_cwl;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   rdy_mode = 0;  // 0 random, 1 forced low, 2 forced high
    int unsigned last_hs = 0;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Expected behaviour straight from the phase rules: total phase time T = S + P + H.
    function automatic exp_t model(input logic [1:0] op, input logic [4:0] col, input logic [4:0] row,
                                   input logic data, input int unsigned plen, input logic [3:0] bo);
        exp_t e;
        int unsigned p, t;
        p         = (plen == 0) ? 1 : plen;
        t         = S + p + H;
        e.op      = op;
        e.col     = col;
        e.row     = row;
        e.acc     = 0;
        e.lat     = t + 1;
        e.rdata   = (op == 2'b11) ? 4'd0 : bo;
        e.n_cblen = (op == 2'b11) ? t : 0;
        e.n_cbl   = ((op == 2'b11 && data) || op == 2'b00) ? t : 0;
        e.n_csl   = (op == 2'b10 || op == 2'b00) ? p : 0;
        e.n_cwl   = (op == 2'b11) ? p : 0;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1:       rsp_ready_i = 1'b0;
            2:       rsp_ready_i = 1'b1;
            default: rsp_ready_i = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor state
    exp_t        hd;
    int unsigned t;
    int unsigned a_cbl, a_cblen, a_csl, a_cwl, f_csl, f_cwl;
    logic        rsp_seen, late_flag;
    logic [3:0]  held;

    task automatic clear_acc();
        a_cbl = 0; a_cblen = 0; a_csl = 0; a_cwl = 0;
        f_csl = 0; f_cwl = 0;
        rsp_seen = 1'b0; late_flag = 1'b0; held = '0;
    endtask

    initial clear_acc();

    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            clear_acc();
        end else if (exp_q.size() == 0 || cyc == exp_q[0].acc) begin
            check("idle_outs", {rsp_valid_o, busy_o, cbl_o, cblen_o, csl_o, cwl_o,
                                instructions_o, addr_col_o, addr_row_o}, 0);
            check("idle_ready", cmd_ready_o, 1);
        end else begin
            hd = exp_q[0];
            t  = cyc - hd.acc;
            if (!rsp_valid_o) begin
                check("phase_outs", {busy_o, cmd_ready_o, instructions_o, addr_col_o, addr_row_o},
                      {1'b1, 1'b0, hd.op, hd.col, hd.row});
                a_cbl   += cbl_o;
                a_cblen += cblen_o;
                a_csl   += csl_o;
                a_cwl   += cwl_o;
                if (csl_o && f_csl == 0) f_csl = t;
                if (cwl_o && f_cwl == 0) f_cwl = t;
                if (t >= hd.lat && !late_flag) begin
                    check("rsp_timeout", t, hd.lat - 1);
                    late_flag = 1'b1;
                end
            end else begin
                check("resp_outs", {busy_o, cmd_ready_o, cbl_o, cblen_o, csl_o, cwl_o,
                                    instructions_o, addr_col_o, addr_row_o},
                      {1'b1, 1'b0, 4'b0000, hd.op, hd.col, hd.row});
                if (!rsp_seen) begin
                    rsp_seen = 1'b1;
                    held     = rsp_data_o;
                    check("rsp_latency", t, hd.lat);
                    check("cbl_cycles", a_cbl, hd.n_cbl);
                    check("cblen_cycles", a_cblen, hd.n_cblen);
                    check("csl_cycles", a_csl, hd.n_csl);
                    check("cwl_cycles", a_cwl, hd.n_cwl);
                    if (hd.n_csl != 0) check("csl_start", f_csl, S + 1);
                    if (hd.n_cwl != 0) check("cwl_start", f_cwl, S + 1);
                end else begin
                    check("rsp_stable", rsp_data_o, held);
                end
                if (rsp_ready_i) begin
                    check("rsp_data", rsp_data_o, hd.rdata);
                    last_hs = cyc;
                    void'(exp_q.pop_front());
                    clear_acc();
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [4:0] col, input logic [4:0] row,
                         input logic data, input int unsigned plen, input logic [3:0] bo,
                         output int unsigned acc);
        exp_t e;
        bit   done;
        done = 0;
        acc  = 0;
        // bit_out may only change once the previous command has captured its result
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy_o || rsp_valid_o) begin
                done = 1;
                break;
            end
        end
        if (!done) check("wait_capture_timeout", 0, 1);
        @(posedge clk);
        #1;
        bit_out_i   = bo;
        cmd_op_i    = op;
        cmd_col_i   = col;
        cmd_row_i   = row;
        cmd_data_i  = data;
        pulse_len_i = PW'(plen);
        cmd_valid_i = 1'b1;
        done        = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                acc   = cyc;
                e     = model(op, col, row, data, plen, bo);
                e.acc = acc;
                exp_q.push_back(e);
                done  = 1;
                break;
            end
        end
        if (!done) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    int unsigned acc_a, acc_b;

    initial begin
        #2 rst_ni = 1'b0;
        #1;
        check("reset_outs", {rsp_valid_o, rsp_data_o, busy_o, cbl_o, cblen_o, csl_o, cwl_o,
                             instructions_o, addr_col_o, addr_row_o}, 0);
        check("reset_ready", cmd_ready_o, 1);
        repeat (3) @(posedge clk);
        #2 rst_ni = 1'b1;
        repeat (2) @(posedge clk);

        // Read_mem, col 5 row 17, pulse 4, bit_out 1010
        rdy_mode = 2;
        issue(2'b10, 5'd5, 5'd17, 1'b0, 4, 4'b1010, acc_a);
        drain();
        // Prog with zero pulse length behaves as one cycle
        issue(2'b11, 5'd3, 5'd9, 1'b1, 0, 4'b1111, acc_a);
        drain();
        // Inference with all-ones pulse length
        issue(2'b00, 5'd31, 5'd0, 1'b0, 255, 4'b0110, acc_a);
        drain();

        // Back-to-back: response held off for 5 cycles, second command waits for handshake
        rdy_mode = 1;
        issue(2'b01, 5'd12, 5'd21, 1'b0, 3, 4'b1001, acc_a);
        fork
            issue(2'b10, 5'd7, 5'd8, 1'b0, 2, 4'b0011, acc_b);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (rsp_valid_o) break;
                end
                repeat (5) @(negedge clk);
                rdy_mode = 2;
            end
        join
        check("b2b_accept", acc_b, last_hs + 1);
        rdy_mode = 0;
        drain();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            issue(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 1'($urandom),
                  $urandom_range(0, 12), 4'($urandom), acc_a);
        end
        drain();

        // Reset during PULSE drops the command and its response
        issue(2'b00, 5'd10, 5'd20, 1'b1, 200, 4'b1100, acc_a);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (csl_o) break;
        end
        check("csl_before_reset", csl_o, 1);
        repeat (3) @(posedge clk);
        #3 rst_ni = 1'b0;
        #1;
        check("async_reset_outs", {rsp_valid_o, busy_o, cbl_o, cblen_o, csl_o, cwl_o,
                                   instructions_o, addr_col_o, addr_row_o}, 0);
        check("async_reset_ready", cmd_ready_o, 1);
        @(posedge clk);
        #2 rst_ni = 1'b1;
        @(negedge clk);
        check("post_reset_ready", cmd_ready_o, 1);
        repeat (300) @(posedge clk);

        // Traffic still works after the reset
        issue(2'b10, 5'd1, 5'd2, 1'b0, 5, 4'b0101, acc_a);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
